// File: rtl/pipeline_sched_ctrl.sv
// rtl/pipeline_sched_ctrl.sv - front-end stall/flush controller with context-switch sequencer
// Optional macro CS_STALL_COUNT_EN adds the context-switch stall-cycle counter.
module pipeline_sched_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             icache_busywait_i,
    input  logic             dcache_busywait_i,
    input  logic             branch_jump_signal_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rd_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             cs_req_i,
    input  logic             cache_switch_done_i,
    output logic             pc_hold_o,
    output logic             if_hold_o,
    output logic             if_flush_o,
    output logic             id_ex_bubble_o,
    output logic             cache_switch_start_o,
    output logic             cs_ack_o,
    output logic             cs_busy_o,
    output logic [CNT_W-1:0] cs_stall_cycles_o
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SWITCH, S_RESUME} state_e;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_e     state_q;
    logic [3:0] drain_cnt_q;
    logic       sw_first_q;

    logic busy;
    logic load_use;
    logic cs_accept;

    assign busy      = icache_busywait_i | dcache_busywait_i;
    assign load_use  = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                       ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    assign cs_accept = (state_q == S_RUN) && cs_req_i && !busy && !branch_jump_signal_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_RUN;
            drain_cnt_q <= 4'd0;
            sw_first_q  <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (cs_accept) begin
                        state_q     <= S_DRAIN;
                        drain_cnt_q <= DRAIN_INIT;
                    end
                end
                S_DRAIN: begin
                    // A busy dcache means the MEM-stage op has not retired, so the drain stalls too.
                    if (!dcache_busywait_i) begin
                        if (drain_cnt_q == 4'd0) begin
                            state_q    <= S_SWITCH;
                            sw_first_q <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q - 4'd1;
                        end
                    end
                end
                S_SWITCH: begin
                    sw_first_q <= 1'b0;
                    if (cache_switch_done_i) begin
                        state_q <= S_RESUME;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    always_comb begin
        pc_hold_o            = 1'b0;
        if_hold_o            = 1'b0;
        if_flush_o           = 1'b0;
        id_ex_bubble_o       = 1'b0;
        cache_switch_start_o = 1'b0;
        cs_ack_o             = 1'b0;
        cs_busy_o            = 1'b0;
        if (rst_ni) begin
            cs_busy_o = (state_q != S_RUN);
            case (state_q)
                S_RUN: begin
                    // A redirect makes the ID instruction wrong-path, so its load-use hazard is moot.
                    if (busy) begin
                        pc_hold_o = 1'b1;
                        if_hold_o = 1'b1;
                    end else if (branch_jump_signal_i) begin
                        if_flush_o     = 1'b1;
                        id_ex_bubble_o = 1'b1;
                    end else if (load_use) begin
                        pc_hold_o      = 1'b1;
                        if_hold_o      = 1'b1;
                        id_ex_bubble_o = 1'b1;
                    end
                end
                S_DRAIN: begin
                    pc_hold_o  = 1'b1;
                    if_flush_o = 1'b1;
                end
                S_SWITCH: begin
                    pc_hold_o            = 1'b1;
                    if_flush_o           = 1'b1;
                    cache_switch_start_o = sw_first_q;
                end
                default: begin
                    cs_ack_o = 1'b1;
                end
            endcase
        end
    end

`ifdef CS_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (cs_accept) begin
            stall_cnt_q <= '0;
        end else if ((state_q != S_RUN) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign cs_stall_cycles_o = stall_cnt_q;
`else
    assign cs_stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_sched_ctrl.sv
// tb/tb_pipeline_sched_ctrl.sv - directed scoreboard bench for pipeline_sched_ctrl
module tb_pipeline_sched_ctrl;

    localparam int CNT_W = 16;
`ifdef CS_STALL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // {pc_hold, if_hold, if_flush, id_ex_bubble, cache_switch_start, cs_ack, cs_busy}
    localparam logic [6:0] O_ZERO = 7'b0000000;
    localparam logic [6:0] O_HOLD = 7'b1100000;
    localparam logic [6:0] O_LU   = 7'b1101000;
    localparam logic [6:0] O_BR   = 7'b0011000;
    localparam logic [6:0] O_DRN  = 7'b1010001;
    localparam logic [6:0] O_STA  = 7'b1010101;
    localparam logic [6:0] O_ACK  = 7'b0000011;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             icache_busywait_i = 1'b0;
    logic             dcache_busywait_i = 1'b0;
    logic             branch_jump_signal_i = 1'b0;
    logic             ex_mem_read_i = 1'b0;
    logic [4:0]       ex_rd_i = 5'd0;
    logic [4:0]       id_rs1_i = 5'd0;
    logic [4:0]       id_rs2_i = 5'd0;
    logic             cs_req_i = 1'b0;
    logic             cache_switch_done_i = 1'b0;
    logic             pc_hold_o;
    logic             if_hold_o;
    logic             if_flush_o;
    logic             id_ex_bubble_o;
    logic             cache_switch_start_o;
    logic             cs_ack_o;
    logic             cs_busy_o;
    logic [CNT_W-1:0] cs_stall_cycles_o;

    logic [22:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;
    int          stall_model = 0;

    always #5 clk_i = ~clk_i;

    pipeline_sched_ctrl #(.DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .icache_busywait_i   (icache_busywait_i),
        .dcache_busywait_i   (dcache_busywait_i),
        .branch_jump_signal_i(branch_jump_signal_i),
        .ex_mem_read_i       (ex_mem_read_i),
        .ex_rd_i             (ex_rd_i),
        .id_rs1_i            (id_rs1_i),
        .id_rs2_i            (id_rs2_i),
        .cs_req_i            (cs_req_i),
        .cache_switch_done_i (cache_switch_done_i),
        .pc_hold_o           (pc_hold_o),
        .if_hold_o           (if_hold_o),
        .if_flush_o          (if_flush_o),
        .id_ex_bubble_o      (id_ex_bubble_o),
        .cache_switch_start_o(cache_switch_start_o),
        .cs_ack_o            (cs_ack_o),
        .cs_busy_o           (cs_busy_o),
        .cs_stall_cycles_o   (cs_stall_cycles_o)
    );

    function automatic logic [15:0] sexp(input int v);
        return CNT_EN ? 16'(v) : 16'd0;
    endfunction

    task automatic chk(input string tag, input logic [6:0] o, input int stall);
        logic [22:0] obs;
        logic [22:0] e;
        string       t;
        exp_q.push_back({o, sexp(stall)});
        tag_q.push_back(tag);
        @(negedge clk_i);
        obs = {pc_hold_o, if_hold_o, if_flush_o, id_ex_bubble_o,
               cache_switch_start_o, cs_ack_o, cs_busy_o, cs_stall_cycles_o};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_hazards();
        branch_jump_signal_i = 1'b0;
        ex_mem_read_i        = 1'b0;
        ex_rd_i              = 5'd0;
        id_rs1_i             = 5'd0;
        id_rs2_i             = 5'd0;
        icache_busywait_i    = 1'b0;
        dcache_busywait_i    = 1'b0;
    endtask

    // nb: dcache busy cycles injected in DRAIN (0 or 2); done arrives 3 cycles after start.
    task automatic cs_run(input int nb, input int prev);
        int s;
        cs_req_i = 1'b1;
        chk("cs_accept", O_ZERO, prev);
        tick();
        for (int c = 1; c <= 4 + nb; c++) begin
            branch_jump_signal_i = (c == 1);
            ex_mem_read_i        = (c == 1);
            ex_rd_i              = 5'd5;
            id_rs1_i             = 5'd5;
            dcache_busywait_i    = (nb > 0) && (c == 2 || c == 3);
            chk("cs_drain", O_DRN, c - 1);
            tick();
        end
        clear_hazards();
        s = 5 + nb;
        chk("cs_start", O_STA, s - 1);
        tick();
        for (int c = s + 1; c <= s + 3; c++) begin
            cache_switch_done_i = (c == s + 3);
            chk("cs_switch", O_DRN, c - 1);
            tick();
        end
        cache_switch_done_i = 1'b0;
        chk("cs_ack", O_ACK, s + 3);
        cs_req_i = 1'b0;
        tick();
        chk("cs_idle", O_ZERO, s + 4);
        stall_model = s + 4;
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("reset_low", O_ZERO, 0);
        tick();
        rst_ni = 1'b1;
        chk("post_reset", O_ZERO, 0);
        tick();

        ex_mem_read_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd3; id_rs2_i = 5'd5;
        chk("lu_rs2", O_LU, 0);
        tick();
        ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_rs2_i = 5'd1;
        chk("lu_rs1", O_LU, 0);
        tick();
        ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
        chk("lu_rd0", O_ZERO, 0);
        tick();
        ex_mem_read_i = 1'b0; ex_rd_i = 5'd9; id_rs1_i = 5'd9;
        chk("no_load", O_ZERO, 0);
        tick();
        ex_mem_read_i = 1'b1; branch_jump_signal_i = 1'b1;
        chk("br_over_lu", O_BR, 0);
        tick();
        icache_busywait_i = 1'b1;
        chk("busy_over_br", O_HOLD, 0);
        tick();
        clear_hazards();
        dcache_busywait_i = 1'b1;
        chk("dcache_hold", O_HOLD, 0);
        tick();
        clear_hazards();
        branch_jump_signal_i = 1'b1;
        chk("br_only", O_BR, 0);
        tick();
        clear_hazards();

        cs_run(0, stall_model);
        cs_run(2, stall_model);

        icache_busywait_i = 1'b1;
        cs_req_i = 1'b1;
        chk("cs_wait_ic0", O_HOLD, stall_model);
        tick();
        chk("cs_wait_ic1", O_HOLD, stall_model);
        tick();
        icache_busywait_i = 1'b0;
        cs_run(0, stall_model);

        cs_req_i = 1'b1;
        chk("rst_accept", O_ZERO, stall_model);
        tick();
        chk("rst_drain", O_DRN, 0);
        tick();
        rst_ni = 1'b0;
        cs_req_i = 1'b0;
        chk("rst_mid", O_ZERO, 0);
        tick();
        chk("rst_hold", O_ZERO, 0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_after", O_ZERO, 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_sched_ctrl.md
# pipeline_sched_ctrl

Central stall/flush controller for the front end of the 5-stage RISC-V pipeline. It drives hold and flush controls for PC and the IF/ID pipeline register from cache busywaits, load-use hazards and branch/jump redirects. It also sequences the OS-initiated context switch: drain the pipeline, hand off to the cache-switch logic, then resume fetch. It sits beside the hazard unit, between the caches, the EX stage and the IF/ID register.

## Interface
- DRAIN_CYCLES, 4: cycles of bubble injection needed to empty ID..WB before a cache switch (legal range 1..15).
- CNT_W, 16: width of the context-switch stall counter.

- clk  in  1  pipeline clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- icache_busywait  in  1  instruction cache busy.
- dcache_busywait  in  1  data cache busy.
- branch_jump_signal  in  1  taken branch/jump resolved in EX this cycle.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of EX instruction.
- id_rs1, id_rs2  in  5 each  source registers of ID instruction.
- cs_req  in  1  context-switch request (level, held until cs_ack).
- cache_switch_done  in  1  cache-switch logic finished (single-cycle pulse or level).
- pc_hold  out  1  freeze PC.
- if_hold  out  1  freeze IF/ID register (drives its hold).
- if_flush  out  1  clear IF/ID register (drives hazard_rest).
- id_ex_bubble  out  1  insert NOP into ID/EX.
- cache_switch_start  out  1  one-cycle pulse to cache-switch logic.
- cs_ack  out  1  one-cycle pulse, context switch complete.
- cs_busy  out  1  FSM not in RUN.
- cs_stall_cycles  out  CNT_W  stall cycles of last/current context switch.

## Operation
- FSM states: RUN, DRAIN, SWITCH, RESUME. Reset state RUN.
- RUN hazard outputs, combinational, in priority order:
  - busy = icache_busywait | dcache_busywait -> pc_hold=1, if_hold=1, everything else 0.
  - branch_jump_signal -> if_flush=1, id_ex_bubble=1. Load-use check suppressed because the ID instruction is wrong-path.
  - load_use = ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2) -> pc_hold=1, if_hold=1, id_ex_bubble=1.
  - otherwise all 0.
- RUN -> DRAIN when cs_req=1 & !busy & !branch_jump_signal at a clock edge. The drain counter loads DRAIN_CYCLES-1.
- DRAIN: pc_hold=1 and if_flush=1 (bubbles enter IF/ID), id_ex_bubble=0.
  - Counter decrements only in cycles with dcache_busywait=0.
  - When the counter is 0 and dcache_busywait=0 -> SWITCH.
- SWITCH:
  - First cycle: cache_switch_start=1.
  - Hold pc_hold=1, if_flush=1 until cache_switch_done=1 is sampled -> RESUME.
  - A done pulse arriving in the first SWITCH cycle is accepted.
- RESUME: exactly one cycle. cs_ack=1, pc_hold=0, if_flush=0, then -> RUN.
- In any state other than RUN, branch_jump_signal and load_use are ignored. cs_req is ignored outside RUN.
- cs_busy = (state != RUN).
- Reset mid-operation returns to RUN immediately. All outputs go to 0, counters clear, and no cs_ack or cache_switch_start pulse is emitted.

## Timing
- All outputs are 0 while reset is low.
- Hazard outputs are combinational, with zero-cycle latency from their inputs.
- FSM outputs are combinational from registered state.
- Nominal context-switch latency from the accepting edge to cs_ack = DRAIN_CYCLES + 1 + N + 1 cycles, where N is the number of extra SWITCH cycles before done.
- Each dcache_busywait cycle in DRAIN adds one cycle.
- cache_switch_start is high for exactly one cycle per switch.
- cs_ack is high for exactly one cycle per switch.

## Configuration
- CS_STALL_COUNT_EN defined:
  - cs_stall_cycles clears to 0 on the RUN->DRAIN edge.
  - It increments every cycle in DRAIN, SWITCH and RESUME.
  - It saturates at 2^CNT_W-1 and holds its value in RUN.
- CS_STALL_COUNT_EN undefined: cs_stall_cycles is tied to 0 and no counter register exists.

## Test plan
- Reset: drive reset=0 mid-DRAIN -> all outputs 0 and state RUN. After release with cs_req=0 -> no pulses.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> pc_hold=if_hold=id_ex_bubble=1. With ex_rd=0 -> all 0.
- Branch priority: branch_jump_signal=1 with load-use true -> if_flush=1, id_ex_bubble=1, pc_hold=0. Adding icache_busywait=1 -> only pc_hold=if_hold=1.
- Context switch, DRAIN_CYCLES=4, done asserted 3 cycles after start -> cache_switch_start in cycle 5 after accept and cs_ack in cycle 9. cs_stall_cycles=9 when CS_STALL_COUNT_EN is defined, 0 otherwise.
- Drain under dcache_busywait: 2 busy cycles during DRAIN -> cache_switch_start delayed exactly 2 cycles.
- cs_req with icache_busywait=1 -> no transition until busywait drops. It then enters DRAIN on the next edge.
